// File: rtl/pa_sysmap_pkg.sv
// Shared types and address-map constants for the sysmap register-bank bus interface.
package pa_sysmap_pkg;

  localparam int unsigned ADDR_W        = 12;
  localparam int unsigned DATA_W        = 32;
  localparam int unsigned REGION_STRIDE = 8;
  localparam int unsigned FLG_OFFSET    = 4;
  localparam int unsigned MAX_REGION    = 8;

  // Address field positions within the byte offset
  localparam int unsigned IDX_MSB   = 5;
  localparam int unsigned IDX_LSB   = 3;
  localparam int unsigned IDX_W     = IDX_MSB - IDX_LSB + 1;
  localparam int unsigned TYPE_BIT  = 2;
  localparam int unsigned ALIGN_MSB = 1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } sysmap_state_t;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } sysmap_req_t;

endpackage

// File: rtl/pa_sysmap_busif_dec.sv
// Decodes a captured byte offset into region one-hot, flag/base select and legality.
module pa_sysmap_busif_dec
  import pa_sysmap_pkg::*;
#(
  parameter int unsigned REGION_NUM = 8
) (
  input  logic [ADDR_W-1:0]     addr,
  output logic [REGION_NUM-1:0] region_onehot,
  output logic                  flg_sel,
  output logic                  legal
);

  logic             fmt_ok;
  logic [IDX_W-1:0] idx;

  // One-hot is empty for any malformed or out-of-range offset, so legal is just its OR
  always_comb begin
    idx           = addr[IDX_MSB:IDX_LSB];
    flg_sel       = addr[TYPE_BIT];
    fmt_ok        = (addr[ALIGN_MSB:0] == '0) && (addr[ADDR_W-1:IDX_MSB+1] == '0);
    region_onehot = '0;
    for (int unsigned i = 0; i < REGION_NUM; i++) begin
      region_onehot[i] = fmt_ok && (idx == IDX_W'(i));
    end
    legal = |region_onehot;
  end

endmodule

// File: rtl/pa_sysmap_busif.sv
// Bus-side writer/reader for the sysmap region register bank: decodes single-word
// transfers into per-region update strobes and returns the selected register value.
module pa_sysmap_busif
  import pa_sysmap_pkg::*;
#(
  parameter int unsigned REGION_NUM = 8
) (
  input  logic                     sysmap_clk,
  input  logic                     cpurst_b,
  input  logic                     ifu_sysmap_rst_sample,
  input  logic                     bus_sysmap_sel,
  input  logic                     bus_sysmap_write,
  input  logic [11:0]              bus_sysmap_addr,
  input  logic [31:0]              bus_sysmap_wdata,
  output logic                     sysmap_bus_ready,
  output logic [31:0]              sysmap_bus_rdata,
  output logic                     sysmap_bus_err,
  output logic [REGION_NUM-1:0]    busif_base_addr_x_updt,
  output logic [REGION_NUM-1:0]    busif_flg_x_updt,
  output logic [31:0]              busif_wdata,
  input  logic [32*REGION_NUM-1:0] busif_base_addr_value,
  input  logic [32*REGION_NUM-1:0] busif_flg_value
);

  sysmap_state_t         cur_state;
  sysmap_state_t         nxt_state;
  sysmap_req_t           hold_q;
  logic [REGION_NUM-1:0] dec_onehot;
  logic                  dec_flg;
  logic                  dec_legal;
  logic                  accept;
  logic                  exec_go;
  logic [DATA_W-1:0]     rd_sel;

  pa_sysmap_busif_dec #(
    .REGION_NUM (REGION_NUM)
  ) u_dec (
    .addr          (hold_q.addr),
    .region_onehot (dec_onehot),
    .flg_sel       (dec_flg),
    .legal         (dec_legal)
  );

  // The IFU reset sample owns the registers; the bus neither accepts nor completes under it
  assign accept      = (cur_state == IDLE) && bus_sysmap_sel && !ifu_sysmap_rst_sample;
  assign exec_go     = (cur_state == EXEC) && !ifu_sysmap_rst_sample;
  assign busif_wdata = hold_q.wdata;

  always_ff @(posedge sysmap_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      cur_state <= IDLE;
    end else begin
      cur_state <= nxt_state;
    end
  end

  always_comb begin
    nxt_state = cur_state;
    case (cur_state)
      IDLE:    if (accept)  nxt_state = EXEC;
      EXEC:    if (exec_go) nxt_state = RESP;
      RESP:    nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase
  end

  // Strobes track the live state so an async reset or a sample cycle kills them at once
  always_comb begin
    busif_base_addr_x_updt = '0;
    busif_flg_x_updt       = '0;
    if (exec_go && hold_q.write) begin
      if (dec_flg) busif_flg_x_updt       = dec_onehot;
      else         busif_base_addr_x_updt = dec_onehot;
    end
  end

  always_comb begin
    rd_sel = '0;
    for (int unsigned i = 0; i < REGION_NUM; i++) begin
      if (dec_onehot[i]) begin
        rd_sel = dec_flg ? busif_flg_value[32*i +: 32] : busif_base_addr_value[32*i +: 32];
      end
    end
  end

  always_ff @(posedge sysmap_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      hold_q           <= '0;
      sysmap_bus_ready <= 1'b0;
      sysmap_bus_rdata <= '0;
      sysmap_bus_err   <= 1'b0;
    end else begin
      sysmap_bus_ready <= exec_go;
      if (accept) begin
        hold_q.write <= bus_sysmap_write;
        hold_q.addr  <= bus_sysmap_addr;
        hold_q.wdata <= bus_sysmap_wdata;
      end
      if (exec_go) begin
        sysmap_bus_rdata <= (!hold_q.write && dec_legal) ? rd_sel : '0;
        sysmap_bus_err   <= !dec_legal;
      end
    end
  end

endmodule
